room_sequencer: RTL
===================

ROOM_SEQUENCER -- requirements
Module: room_sequencer

Interface
REQ-001 SHALL have port CLOCK_25, input, 1 bit: the single clock (25 MHz pixel clock); all logic on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port frame_tick, input, 1 bit: one-cycle pulse per frame, at v_counter==0 and h_counter==0.
REQ-004 SHALL have port btn_start, input, 1 bit: level input, already debounced.
REQ-005 SHALL have ports player_x and player_y, input, 10 bits each: player top-left position in counter coordinates (sprite is 16x16).
REQ-006 SHALL have port spawn_ack, input, 1 bit: player block has loaded spawn_x/spawn_y.
REQ-007 SHALL have ports room_x and room_y, output, 2 bits each: current grid cell, 0..2.
REQ-008 SHALL have port room_code, output, 4 bits: tile code of the current cell (0 vertical, 1 horizontal, 2..5 L1..L4, 6 crossroads).
REQ-009 SHALL have ports spawn_valid (1 bit), spawn_x (10 bits) and spawn_y (10 bits), all outputs: teleport request to the player block.
REQ-010 SHALL have port fade_level, output, 3 bits: brightness, 7 = full, 0 = black.
REQ-011 SHALL have ports freeze and win, output, 1 bit each.

Function
REQ-012 SHALL implement the states TITLE, PLAY, FADE_OUT, LOAD, SPAWN, FADE_IN and WIN.
REQ-013 TITLE SHALL hold freeze=1; on btn_start high it SHALL go to SPAWN with room (0,0) and spawn (400,240).
REQ-014 PLAY SHALL hold freeze=0 and SHALL sample the edges only on a cycle where frame_tick is high.
REQ-015 Edge detection: exit left if player_x<=97, right if player_x>=720, up if player_y<=3, down if player_y>=466.
REQ-016 When several edges hold in the same cycle, priority SHALL be left > right > up > down.
REQ-017 An exit toward a cell outside the 3x3 grid SHALL be ignored: stay in PLAY, room unchanged.
REQ-018 A valid exit SHALL latch the direction and go to FADE_OUT with freeze=1.
REQ-019 FADE_OUT SHALL decrement fade_level by 1 per frame_tick; when fade_level reaches 0 it SHALL go to LOAD.
REQ-020 LOAD SHALL last exactly 1 cycle and SHALL update room_x/room_y by ±1 in the latched direction.
REQ-021 LOAD SHALL set the spawn point on the opposite edge, keeping the other coordinate: left exit gives x=704, right gives x=113, up gives y=450, down gives y=19.
REQ-022 SPAWN SHALL assert spawn_valid with spawn_x/spawn_y held stable until the first cycle with spawn_ack=1.
REQ-023 On that cycle spawn_valid SHALL deassert on the next edge, and the block SHALL go to FADE_IN.
REQ-024 spawn_ack while spawn_valid=0 SHALL be ignored.
REQ-025 FADE_IN SHALL increment fade_level by 1 per frame_tick; at 7 it SHALL go to PLAY, or to WIN if the room is (2,2).
REQ-026 WIN SHALL hold win=1, freeze=1 and fade_level=7; a rising edge of btn_start SHALL go to TITLE.
REQ-027 room_code SHALL be a registered lookup of the map table, valid 1 cycle after a room change.
REQ-028 fade_level SHALL never wrap below 0 or above 7.

Reset
REQ-029 reset SHALL act immediately in any state, including mid-fade and mid-handshake.
REQ-030 Reset values: state TITLE, room (0,0), room_code 4, spawn_valid 0, spawn_x 400, spawn_y 240, fade_level 7, freeze 1, win 0, latched direction cleared.

Configuration
REQ-031 With ROOM_FADE_EN defined, the FADE_OUT and FADE_IN behaviour SHALL be exactly as above.
REQ-032 Without ROOM_FADE_EN, PLAY SHALL go directly to LOAD and SPAWN directly to PLAY or WIN, and fade_level SHALL stay constant at 7.

Structure
REQ-033 A shared package SHALL hold the state encoding, the direction encoding, the edge and spawn constants, the 3x3 map table (rows 4,1,5 / 0,6,0 / 3,1,2), the start room and the goal room.
REQ-034 One sub-module, edge_detector, SHALL be combinational: player_x/player_y/room_x/room_y in, direction plus valid out, including the priority and grid-bounds rules.

Verification
REQ-035 Reset, then btn_start=1 -> SPAWN with spawn (400,240); ack -> PLAY with freeze=0 and room_code=4.
REQ-036 In room (0,0), player_x=97 at frame_tick -> no transition and room stays (0,0); player_x=720 -> fade 7→0 over 7 ticks, room (1,0), spawn_x=113.
REQ-037 player_x=97 and player_y=466 in room (1,1) at frame_tick -> left exit wins, room becomes (0,1).
REQ-038 In SPAWN, spawn_ack held 0 for 100 cycles -> spawn_valid stays 1 with stable coordinates; ack=1 -> spawn_valid=0 on the next cycle.
REQ-039 Enter room (2,2) -> after fade-in, win=1 and freeze=1; btn_start rising edge -> TITLE.
REQ-040 Assert reset during FADE_OUT at fade_level=3 -> all outputs at reset values on the same edge; build without ROOM_FADE_EN -> fade_level stays 7 throughout.

Source files
------------

// File: rtl/room_sequencer_pkg.sv
// Shared definitions for the room sequencer: FSM state and exit-direction
// encodings, screen-edge and spawn-point constants, the 3x3 room map and
// the start/goal cells.
//
// Build option: ROOM_FADE_EN (used by room_sequencer) enables the
// fade-out/fade-in transitions between rooms.
package room_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_TITLE    = 3'd0,
        ST_PLAY     = 3'd1,
        ST_FADE_OUT = 3'd2,
        ST_LOAD     = 3'd3,
        ST_SPAWN    = 3'd4,
        ST_FADE_IN  = 3'd5,
        ST_WIN      = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_LEFT  = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_UP    = 3'd3,
        DIR_DOWN  = 3'd4
    } dir_e;

    // Player top-left coordinates at which a screen edge counts as reached.
    localparam logic [9:0] EDGE_LEFT_X   = 10'd97;
    localparam logic [9:0] EDGE_RIGHT_X  = 10'd720;
    localparam logic [9:0] EDGE_TOP_Y    = 10'd3;
    localparam logic [9:0] EDGE_BOTTOM_Y = 10'd466;

    // Spawn points: the new room is entered on the edge opposite the exit.
    localparam logic [9:0] SPAWN_START_X     = 10'd400;
    localparam logic [9:0] SPAWN_START_Y     = 10'd240;
    localparam logic [9:0] SPAWN_FROM_LEFT_X  = 10'd704;
    localparam logic [9:0] SPAWN_FROM_RIGHT_X = 10'd113;
    localparam logic [9:0] SPAWN_FROM_UP_Y    = 10'd450;
    localparam logic [9:0] SPAWN_FROM_DOWN_Y  = 10'd19;

    localparam logic [1:0] GRID_MAX = 2'd2;
    localparam logic [1:0] START_X  = 2'd0;
    localparam logic [1:0] START_Y  = 2'd0;
    localparam logic [1:0] GOAL_X   = 2'd2;
    localparam logic [1:0] GOAL_Y   = 2'd2;

    localparam logic [2:0] FADE_MAX = 3'd7;

    localparam logic [3:0] TILE_VERT  = 4'd0;
    localparam logic [3:0] TILE_HORIZ = 4'd1;
    localparam logic [3:0] TILE_L1    = 4'd2;
    localparam logic [3:0] TILE_L2    = 4'd3;
    localparam logic [3:0] TILE_L3    = 4'd4;
    localparam logic [3:0] TILE_L4    = 4'd5;
    localparam logic [3:0] TILE_CROSS = 4'd6;

    // Map rows are indexed by room_y, columns by room_x:
    //   y=0: 4 1 5   y=1: 0 6 0   y=2: 3 1 2
    function automatic logic [3:0] map_lookup(input logic [1:0] x, input logic [1:0] y);
        logic [3:0] code;
        case ({y, x})
            4'b00_00: code = TILE_L3;
            4'b00_01: code = TILE_HORIZ;
            4'b00_10: code = TILE_L4;
            4'b01_00: code = TILE_VERT;
            4'b01_01: code = TILE_CROSS;
            4'b01_10: code = TILE_VERT;
            4'b10_00: code = TILE_L2;
            4'b10_01: code = TILE_HORIZ;
            4'b10_10: code = TILE_L1;
            default:  code = TILE_VERT;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/room_sequencer_edge_detector.sv
// Combinational exit detector.
// Picks the highest-priority screen edge the player touches
// (left > right > up > down) and flags whether the neighbouring cell in that
// direction exists in the 3x3 grid. An exit toward a missing cell reports the
// direction with valid low, so it is simply ignored by the sequencer.
//
// Ports:
//   player_x_i, player_y_i : player top-left position
//   room_x_i, room_y_i     : current grid cell
//   exit_dir_o             : chosen edge (DIR_NONE when no edge reached)
//   exit_valid_o           : chosen edge leads to a cell inside the grid
module edge_detector
    import room_sequencer_pkg::*;
(
    input  logic [9:0] player_x_i,
    input  logic [9:0] player_y_i,
    input  logic [1:0] room_x_i,
    input  logic [1:0] room_y_i,
    output dir_e       exit_dir_o,
    output logic       exit_valid_o
);

    always_comb begin
        exit_dir_o   = DIR_NONE;
        exit_valid_o = 1'b0;
        if (player_x_i <= EDGE_LEFT_X) begin
            exit_dir_o   = DIR_LEFT;
            exit_valid_o = (room_x_i != 2'd0);
        end else if (player_x_i >= EDGE_RIGHT_X) begin
            exit_dir_o   = DIR_RIGHT;
            exit_valid_o = (room_x_i < GRID_MAX);
        end else if (player_y_i <= EDGE_TOP_Y) begin
            exit_dir_o   = DIR_UP;
            exit_valid_o = (room_y_i != 2'd0);
        end else if (player_y_i >= EDGE_BOTTOM_Y) begin
            exit_dir_o   = DIR_DOWN;
            exit_valid_o = (room_y_i < GRID_MAX);
        end
    end

endmodule

// File: rtl/room_sequencer.sv
// Room sequencer: walks the player through a 3x3 grid of rooms, handling
// screen-edge exits, the teleport handshake with the player block, optional
// fade transitions and the title/win screens.
//
// Build option: ROOM_FADE_EN -- when defined, room changes fade out to black
// and back in, one brightness step per frame_tick. When undefined, rooms swap
// instantly and fade_level stays at 7.
//
// Ports:
//   CLOCK_25    : 25 MHz pixel clock, rising edge
//   reset       : asynchronous, active-high
//   frame_tick  : one-cycle pulse per frame
//   btn_start   : debounced start button level
//   player_x/y  : player top-left position
//   spawn_ack   : player block has taken spawn_x/spawn_y
//   room_x/y    : current grid cell
//   room_code   : tile code of the current cell (one cycle after a change)
//   spawn_valid, spawn_x, spawn_y : teleport request
//   fade_level  : brightness, 7 full .. 0 black
//   freeze, win : player freeze and win-screen flags
//
// state    | meaning
// ---------+-----------------------------------------------------------
// TITLE    | title screen, waiting for btn_start
// PLAY     | player moving, edges checked on frame_tick
// FADE_OUT | darkening one step per frame_tick before the room swap
// LOAD     | single cycle: move to the neighbouring cell, pick spawn point
// SPAWN    | teleport request held until spawn_ack
// FADE_IN  | brightening one step per frame_tick after the swap
// WIN      | goal reached, waiting for a btn_start rising edge
module room_sequencer
    import room_sequencer_pkg::*;
(
    input  logic       CLOCK_25,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_start,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic       spawn_ack,
    output logic [1:0] room_x,
    output logic [1:0] room_y,
    output logic [3:0] room_code,
    output logic       spawn_valid,
    output logic [9:0] spawn_x,
    output logic [9:0] spawn_y,
    output logic [2:0] fade_level,
    output logic       freeze,
    output logic       win
);

    state_e     state_q, state_d;
    dir_e       dir_q, dir_d;
    logic [1:0] room_x_q, room_x_d;
    logic [1:0] room_y_q, room_y_d;
    logic [3:0] room_code_q;
    logic [9:0] spawn_x_q, spawn_x_d;
    logic [9:0] spawn_y_q, spawn_y_d;
    logic [2:0] fade_q, fade_d;
    logic       btn_prev_q;

    dir_e       exit_dir;
    logic       exit_valid;
    logic       at_goal;
    state_e     arrive_state;

    edge_detector u_edge_detector (
        .player_x_i   (player_x),
        .player_y_i   (player_y),
        .room_x_i     (room_x_q),
        .room_y_i     (room_y_q),
        .exit_dir_o   (exit_dir),
        .exit_valid_o (exit_valid)
    );

    assign at_goal      = (room_x_q == GOAL_X) && (room_y_q == GOAL_Y);
    assign arrive_state = at_goal ? ST_WIN : ST_PLAY;

    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            state_q     <= ST_TITLE;
            dir_q       <= DIR_NONE;
            room_x_q    <= START_X;
            room_y_q    <= START_Y;
            room_code_q <= map_lookup(START_X, START_Y);
            spawn_x_q   <= SPAWN_START_X;
            spawn_y_q   <= SPAWN_START_Y;
            fade_q      <= FADE_MAX;
            btn_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            room_x_q    <= room_x_d;
            room_y_q    <= room_y_d;
            room_code_q <= map_lookup(room_x_q, room_y_q);
            spawn_x_q   <= spawn_x_d;
            spawn_y_q   <= spawn_y_d;
            fade_q      <= fade_d;
            btn_prev_q  <= btn_start;
        end
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        room_x_d  = room_x_q;
        room_y_d  = room_y_q;
        spawn_x_d = spawn_x_q;
        spawn_y_d = spawn_y_q;
        fade_d    = fade_q;

        case (state_q)
            ST_TITLE: begin
                fade_d = FADE_MAX;
                if (btn_start) begin
                    state_d   = ST_SPAWN;
                    dir_d     = DIR_NONE;
                    room_x_d  = START_X;
                    room_y_d  = START_Y;
                    spawn_x_d = SPAWN_START_X;
                    spawn_y_d = SPAWN_START_Y;
                end
            end

            ST_PLAY: begin
                if (frame_tick && exit_valid) begin
                    dir_d = exit_dir;
`ifdef ROOM_FADE_EN
                    state_d = ST_FADE_OUT;
`else
                    state_d = ST_LOAD;
`endif
                end
            end

            ST_FADE_OUT: begin
`ifdef ROOM_FADE_EN
                if (frame_tick) begin
                    if (fade_q != 3'd0) begin
                        fade_d = fade_q - 3'd1;
                    end
                    // Leave on the tick that lands on black.
                    if (fade_q <= 3'd1) begin
                        state_d = ST_LOAD;
                    end
                end
`else
                state_d = ST_LOAD;
`endif
            end

            ST_LOAD: begin
                state_d = ST_SPAWN;
                case (dir_q)
                    DIR_LEFT: begin
                        room_x_d  = room_x_q - 2'd1;
                        spawn_x_d = SPAWN_FROM_LEFT_X;
                        spawn_y_d = player_y;
                    end
                    DIR_RIGHT: begin
                        room_x_d  = room_x_q + 2'd1;
                        spawn_x_d = SPAWN_FROM_RIGHT_X;
                        spawn_y_d = player_y;
                    end
                    DIR_UP: begin
                        room_y_d  = room_y_q - 2'd1;
                        spawn_x_d = player_x;
                        spawn_y_d = SPAWN_FROM_UP_Y;
                    end
                    DIR_DOWN: begin
                        room_y_d  = room_y_q + 2'd1;
                        spawn_x_d = player_x;
                        spawn_y_d = SPAWN_FROM_DOWN_Y;
                    end
                    default: begin
                    end
                endcase
            end

            ST_SPAWN: begin
                // Already at full brightness (start of game, or no fades):
                // nothing to fade in, go straight on.
                if (spawn_ack) begin
                    state_d = (fade_q == FADE_MAX) ? arrive_state : ST_FADE_IN;
                end
            end

            ST_FADE_IN: begin
`ifdef ROOM_FADE_EN
                if (frame_tick) begin
                    if (fade_q != FADE_MAX) begin
                        fade_d = fade_q + 3'd1;
                    end
                    if (fade_q >= FADE_MAX - 3'd1) begin
                        state_d = arrive_state;
                    end
                end
`else
                state_d = arrive_state;
`endif
            end

            ST_WIN: begin
                fade_d = FADE_MAX;
                if (btn_start && !btn_prev_q) begin
                    state_d = ST_TITLE;
                end
            end

            default: begin
                state_d = ST_TITLE;
            end
        endcase
    end

    assign room_x      = room_x_q;
    assign room_y      = room_y_q;
    assign room_code   = room_code_q;
    assign spawn_valid = (state_q == ST_SPAWN);
    assign spawn_x     = spawn_x_q;
    assign spawn_y     = spawn_y_q;
    assign fade_level  = fade_q;
    assign freeze      = (state_q != ST_PLAY);
    assign win         = (state_q == ST_WIN);

endmodule
